// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and RAM-side signal bundle for mem_arbiter
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        ihit;

   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dhit;

   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter onto one RAM port
// Optional watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

   localparam logic [1:0]  RAM_ACCESS = 2'd2;
   localparam logic [1:0]  RAM_ERROR  = 2'd3;
   localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

   state_t      state, next_state;
   logic        last_data;
   logic        lat_wr;
   logic        lat_data;
   logic [31:0] lat_addr;
   logic [31:0] lat_store;
   logic [31:0] iload_q, dload_q;
   logic        ihit_q, dhit_q, err_q;

   logic        data_req;
   logic        grant_i, grant_d;
   logic        busy;
   logic        done;
   logic        abnormal;
   logic        timeout_hit;

   assign data_req = bus.dREN | bus.dWEN;
   // On a tie the side that did not win last time gets the grant.
   assign grant_d  = data_req  & (~bus.iREN | ~last_data);
   assign grant_i  = bus.iREN  & (~data_req | last_data);
   assign busy     = (state == IBUSY) || (state == DBUSY);
   assign done     = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR) || timeout_hit;
   assign abnormal = (bus.ramstate != RAM_ACCESS);

`ifdef MEM_ARBITER_TIMEOUT_EN
   logic [7:0] to_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         to_cnt <= 8'd0;
      end else if (state == IDLE && (grant_i || grant_d)) begin
         to_cnt <= 8'd0;
      end else if (busy) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   assign timeout_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_d)      next_state = DBUSY;
            else if (grant_i) next_state = IBUSY;
         end
         IBUSY, DBUSY: begin
            if (done) next_state = RESP;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         last_data <= 1'b0;
         lat_wr    <= 1'b0;
         lat_data  <= 1'b0;
         lat_addr  <= 32'd0;
         lat_store <= 32'd0;
         iload_q   <= 32'd0;
         dload_q   <= 32'd0;
         ihit_q    <= 1'b0;
         dhit_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state  <= next_state;
         ihit_q <= 1'b0;
         dhit_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  last_data <= 1'b1;
                  lat_data  <= 1'b1;
                  lat_wr    <= bus.dWEN;
                  lat_addr  <= bus.daddr;
                  lat_store <= bus.dstore;
               end else if (grant_i) begin
                  last_data <= 1'b0;
                  lat_data  <= 1'b0;
                  lat_wr    <= 1'b0;
                  lat_addr  <= bus.iaddr;
                  lat_store <= 32'd0;
               end
            end
            IBUSY, DBUSY: begin
               // Hit flags are set on the transition so they line up with RESP.
               if (done) begin
                  err_q <= abnormal;
                  if (lat_data) begin
                     dhit_q <= 1'b1;
                     if (abnormal)     dload_q <= ERR_WORD;
                     else if (!lat_wr) dload_q <= bus.ramload;
                  end else begin
                     ihit_q  <= 1'b1;
                     iload_q <= abnormal ? ERR_WORD : bus.ramload;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ramREN   = busy & ~lat_wr;
   assign bus.ramWEN   = busy &  lat_wr;
   assign bus.ramaddr  = busy ? lat_addr  : 32'd0;
   assign bus.ramstore = busy ? lat_store : 32'd0;

   assign bus.iload = iload_q;
   assign bus.dload = dload_q;
   assign bus.ihit  = ihit_q;
   assign bus.dhit  = dhit_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.iREN     = 1'b0;
      bus.iaddr    = 32'd0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = 32'd0;
      bus.dstore   = 32'd0;
      bus.ramload  = 32'd0;
      bus.ramstate = 2'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      logic [3:0] seq;
      int         n;
      int         hits;

      total = 0;
      bad   = 0;
      do_reset();

      chk("rst_iload",    bus.iload,    32'd0);
      chk("rst_dload",    bus.dload,    32'd0);
      chk("rst_hits",     {bus.ihit, bus.dhit, bus.err}, 32'd0);
      chk("rst_ram_en",   {bus.ramREN, bus.ramWEN},      32'd0);
      chk("rst_ramaddr",  bus.ramaddr,  32'd0);
      chk("rst_ramstore", bus.ramstore, 32'd0);

      // Data read, two BUSY cycles then ACCESS; request drops after grant.
      bus.dREN = 1'b1; bus.daddr = 32'h100;
      bus.ramstate = 2'd1; bus.ramload = 32'hDEADBEEF;
      tick();
      chk("rd_ramREN",  bus.ramREN,  32'd1);
      chk("rd_ramWEN",  bus.ramWEN,  32'd0);
      chk("rd_ramaddr", bus.ramaddr, 32'h100);
      bus.dREN = 1'b0;
      tick();
      chk("rd_nohit_t2", bus.dhit, 32'd0);
      tick();
      bus.ramstate = 2'd2;
      chk("rd_nohit_t3", bus.dhit, 32'd0);
      tick();
      chk("rd_dhit",     bus.dhit,   32'd1);
      chk("rd_dload",    bus.dload,  32'hDEADBEEF);
      chk("rd_ihit",     bus.ihit,   32'd0);
      chk("rd_err",      bus.err,    32'd0);
      chk("rd_ram_drop", bus.ramREN, 32'd0);
      bus.ramstate = 2'd1;
      tick();
      chk("rd_dhit_once", bus.dhit,  32'd0);
      chk("rd_dload_hold", bus.dload, 32'hDEADBEEF);

      // Simultaneous fetch and data write after reset: data wins first.
      do_reset();
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
      bus.ramstate = 2'd2; bus.ramload = 32'hCAFEF00D;
      tick();
      chk("wr_ramWEN",   bus.ramWEN,   32'd1);
      chk("wr_ramREN",   bus.ramREN,   32'd0);
      chk("wr_ramaddr",  bus.ramaddr,  32'h200);
      chk("wr_ramstore", bus.ramstore, 32'h12345678);
      tick();
      chk("wr_dhit",      bus.dhit,  32'd1);
      chk("wr_ihit",      bus.ihit,  32'd0);
      chk("wr_dload_unc", bus.dload, 32'd0);
      bus.dWEN = 1'b0;
      tick();
      chk("wr_dhit_off", bus.dhit, 32'd0);
      tick();
      chk("if_ramREN",  bus.ramREN,  32'd1);
      chk("if_ramWEN",  bus.ramWEN,  32'd0);
      chk("if_ramaddr", bus.ramaddr, 32'h40);
      tick();
      chk("if_ihit",  bus.ihit,  32'd1);
      chk("if_iload", bus.iload, 32'hCAFEF00D);
      chk("if_dhit",  bus.dhit,  32'd0);
      bus.iREN = 1'b0;
      tick();
      chk("if_ihit_off", bus.ihit, 32'd0);

      // Both sides held: grants must alternate, starting with data.
      bus.iREN = 1'b1; bus.iaddr = 32'h44;
      bus.dREN = 1'b1; bus.daddr = 32'h204;
      bus.ramload = 32'h11112222; bus.ramstate = 2'd2;
      seq = 4'd0;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         tick();
         if (bus.ihit && bus.dhit) n = 99;
         else if (bus.dhit) begin seq[n] = 1'b1; n++; end
         else if (bus.ihit) begin seq[n] = 1'b0; n++; end
      end
      bus.iREN = 1'b0; bus.dREN = 1'b0;
      chk("rr_count", n,   32'd4);
      chk("rr_order", seq, 32'b0101);
      chk("rr_iload", bus.iload, 32'h11112222);
      chk("rr_dload", bus.dload, 32'h11112222);
      tick();

      // ERROR during a fetch.
      bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = 2'd3;
      tick();
      bus.iREN = 1'b0;
      tick();
      chk("er_ihit",  bus.ihit,  32'd1);
      chk("er_err",   bus.err,   32'd1);
      chk("er_iload", bus.iload, 32'hBAD1BAD1);
      chk("er_dhit",  bus.dhit,  32'd0);
      bus.ramstate = 2'd1;
      tick();
      chk("er_err_off", bus.err, 32'd0);

      // Reset in the middle of a data read.
      bus.dREN = 1'b1; bus.daddr = 32'h300;
      tick();
      chk("mr_ramREN_busy", bus.ramREN, 32'd1);
      RST = 1'b1;
      tick();
      chk("mr_ramREN",  bus.ramREN,  32'd0);
      chk("mr_ramaddr", bus.ramaddr, 32'd0);
      chk("mr_hits",    {bus.ihit, bus.dhit, bus.err}, 32'd0);
      chk("mr_iload",   bus.iload,   32'd0);
      chk("mr_dload",   bus.dload,   32'd0);
      RST = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd2;
      hits = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         hits += int'(bus.dhit);
      end
      chk("mr_no_dhit", hits, 32'd0);

      // RAM stuck BUSY.
      bus.ramstate = 2'd1;
      bus.dREN = 1'b1; bus.daddr = 32'h400;
      tick();
      bus.dREN = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      hits = 0;
      for (int c = 0; c < 7; c++) begin
         tick();
         hits += int'(bus.dhit);
      end
      chk("to_early", hits, 32'd0);
      tick();
      chk("to_dhit",  bus.dhit,   32'd1);
      chk("to_err",   bus.err,    32'd1);
      chk("to_dload", bus.dload,  32'hBAD1BAD1);
      chk("to_drop",  bus.ramREN, 32'd0);
`else
      hits = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         hits += int'(bus.dhit) + int'(bus.err);
      end
      chk("nt_no_hit", hits,       32'd0);
      chk("nt_wait",   bus.ramREN, 32'd1);
`endif
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 64, giving the watchdog limit in cycles (used only with MEM_ARBITER_TIMEOUT_EN).
REQ-002 The module SHALL have port CLK  in  1  the single clock; all state updates on the posedge.
REQ-003 The module SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 The module SHALL have the fetch-side ports iREN in 1, iaddr in 32, iload out 32, ihit out 1.
REQ-005 The module SHALL have the data-side ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dload out 32, dhit out 1.
REQ-006 The module SHALL have the RAM-side ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in 2 (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-007 The module SHALL have port err  out  1  a one-cycle pulse coincident with a hit that completed abnormally.

Function
REQ-008 The FSM SHALL have exactly four states: IDLE, IBUSY, DBUSY, RESP.
REQ-009 In IDLE, the FSM SHALL go to DBUSY if (dREN|dWEN) is high and iREN is low; to IBUSY if iREN is high and data is idle; when both are pending, it SHALL grant the side not granted last (round-robin).
REQ-010 On grant, the module SHALL latch the address, the op (write if dWEN, else read) and dstore; dWEN SHALL take precedence over a simultaneous dREN.
REQ-011 In IBUSY/DBUSY, the RAM outputs SHALL be driven from the latched values only: ramREN = latched read, ramWEN = latched write; in all other states they SHALL be 0.
REQ-012 In IBUSY/DBUSY with ramstate==ACCESS, the module SHALL capture ramload (reads) and go to RESP; with ramstate==ERROR, it SHALL capture 32'hBAD1BAD1, set the pending error, and go to RESP.
REQ-013 In RESP, the module SHALL assert exactly one of ihit/dhit for one cycle, with iload/dload holding the captured word, and SHALL return to IDLE.
REQ-014 The response SHALL be held registered: iload/dload keep their last value until the next completion on that side.
REQ-015 Latency SHALL be: request sampled in IDLE at cycle t, RAM request from t+1, ACCESS seen at cycle t+1+k, hit at cycle t+2+k (minimum 3 cycles).
REQ-016 A request that drops before its hit SHALL not abort the transaction; the transaction SHALL complete and the hit SHALL still pulse.
REQ-017 Requests SHALL be ignored during RESP (one bubble); the requester deasserts or reissues after sampling the hit.
REQ-018 For a write completion, dload SHALL be unchanged.
REQ-019 err SHALL pulse in RESP only for ERROR or timeout completions.

Reset
REQ-020 While RST is high at a posedge, state SHALL become IDLE; iload, dload = 0; ihit, dhit, err, ramREN, ramWEN = 0; ramaddr, ramstore = 0; last-grant = fetch (data wins the first tie); timeout counter = 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no hit pulse, and the RAM request SHALL drop in the cycle after the reset edge.

Configuration
REQ-022 With MEM_ARBITER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on grant and increment each IBUSY/DBUSY cycle.
REQ-023 With MEM_ARBITER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without ACCESS, the module SHALL go to RESP with data 32'hBAD1BAD1 and err high, and the RAM request SHALL drop.
REQ-024 Without MEM_ARBITER_TIMEOUT_EN, no counter SHALL exist, the module SHALL wait indefinitely for ACCESS/ERROR, and err SHALL come only from ERROR.

Verification
REQ-025 dREN=1, daddr=0x100, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> dhit pulses once, 4 cycles after the request, with dload=0xDEADBEEF; ihit stays 0.
REQ-026 iREN and dWEN rise in the same cycle after reset -> the data write is granted first, then the fetch; each hit is one cycle; ramWEN and ramREN never overlap.
REQ-027 iREN and dREN held continuously -> grants alternate D, I, D, I; no side waits more than one transaction.
REQ-028 ramstate=ERROR during a fetch -> ihit and err pulse together with iload=0xBAD1BAD1.
REQ-029 RST pulsed during DBUSY -> no dhit; ramREN=0 on the next cycle; all outputs at their reset values.
REQ-030 With MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, ramstate stuck at BUSY -> dhit and err pulse at cycle t+9; without the macro -> no hit after 100 cycles.
